// File: rtl/uc_fsm_pkg.sv
// Shared opcode encodings, FSM state type and control-word helpers for the
// microcontroller control unit.
package uc_fsm_pkg;

  localparam logic [5:0] OP_J      = 6'b100100;
  localparam logic [5:0] OP_JZ     = 6'b100101;
  localparam logic [5:0] OP_JNZ    = 6'b100110;
  localparam logic [5:0] OP_HALT   = 6'b100111;
  localparam logic [3:0] OP_LI_PFX = 4'b1000;

  localparam logic [2:0] ALUOP_LI_DEF = 3'b000;

  typedef enum logic [0:0] {
    StRun  = 1'b0,
    StHalt = 1'b1
  } state_e;

  typedef struct packed {
    logic       s_inc;
    logic       s_inm;
    logic       we;
    logic       wez;
    logic [2:0] alu_op;
  } ctrl_t;

  // Safe no-op: PC advances, nothing is written.
  localparam ctrl_t CTRL_NOP  = '{s_inc: 1'b1, s_inm: 1'b0, we: 1'b0, wez: 1'b0, alu_op: 3'b000};
  // Parked: PC held, nothing is written.
  localparam ctrl_t CTRL_STOP = '{s_inc: 1'b0, s_inm: 1'b0, we: 1'b0, wez: 1'b0, alu_op: 3'b000};

  // 101xxx and 11xxxx are unassigned.
  function automatic logic is_illegal(logic [5:0] op);
    return (op[5:4] == 2'b11) || (op[5:3] == 3'b101);
  endfunction

endpackage

// File: rtl/uc_fsm_if.sv
// Control-unit <-> datapath bundle: opcode/flag in, control word and debug status out.
interface uc_fsm_if #(
  parameter int unsigned CNT_W = 16
);

  logic [5:0]       Opcode;
  logic             zero;
  logic             s_inc;
  logic             s_inm;
  logic             we;
  logic             wez;
  logic [2:0]       ALUOp;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] instr_cnt;

  // Datapath side.
  modport master (
    output Opcode, zero,
    input  s_inc, s_inm, we, wez, ALUOp, halted, illegal, instr_cnt
  );

  // Control-unit side.
  modport slave (
    input  Opcode, zero,
    output s_inc, s_inm, we, wez, ALUOp, halted, illegal, instr_cnt
  );

endinterface

// File: rtl/uc_fsm_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over enable.
module sat_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en && (q != {CNT_W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/uc_fsm.sv
// Single-cycle microcontroller control unit: combinational decode plus RUN/HALT
// supervision, sticky illegal-opcode flag and saturating retired-instruction count.
module uc_fsm
  import uc_fsm_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter logic [2:0]  ALUOP_LI = ALUOP_LI_DEF
) (
  input logic     clk,
  input logic     reset,
  uc_fsm_if.slave bus
);

  state_e           state_q, state_d;
  logic             illegal_q;
  logic [CNT_W-1:0] cnt_q;
  ctrl_t            dec;
  ctrl_t            ctrl;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == StRun && bus.Opcode == OP_HALT) begin
      state_d = StHalt;
    end
  end

  always_comb begin
    dec = CTRL_NOP;
    if (!bus.Opcode[5]) begin
      dec = '{s_inc: 1'b1, s_inm: 1'b0, we: 1'b1, wez: 1'b1, alu_op: bus.Opcode[4:2]};
    end else if (bus.Opcode[5:2] == OP_LI_PFX) begin
      dec = '{s_inc: 1'b1, s_inm: 1'b1, we: 1'b1, wez: 1'b0, alu_op: ALUOP_LI};
    end else begin
      case (bus.Opcode)
        OP_J:    dec = CTRL_STOP;
        OP_JZ:   dec.s_inc = ~bus.zero;
        OP_JNZ:  dec.s_inc = bus.zero;
        OP_HALT: dec = CTRL_STOP;
        default: dec = CTRL_NOP;
      endcase
    end
  end

  // Reset wins over HALT so the datapath sees a harmless NOP while held.
  always_comb begin
    ctrl = dec;
    if (reset) begin
      ctrl = CTRL_NOP;
    end else if (state_q == StHalt) begin
      ctrl = CTRL_STOP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else if (state_q == StRun && is_illegal(bus.Opcode)) begin
      illegal_q <= 1'b1;
    end
  end

  sat_cnt #(
    .CNT_W (CNT_W)
  ) u_instr_cnt (
    .clk (clk),
    .clr (reset),
    .en  (state_q == StRun),
    .q   (cnt_q)
  );

  assign bus.s_inc     = ctrl.s_inc;
  assign bus.s_inm     = ctrl.s_inm;
  assign bus.we        = ctrl.we;
  assign bus.wez       = ctrl.wez;
  assign bus.ALUOp     = ctrl.alu_op;
  assign bus.halted    = (state_q == StHalt);
  assign bus.illegal   = illegal_q;
  assign bus.instr_cnt = cnt_q;

endmodule

// File: tb/tb_uc_fsm.sv
// Randomized self-checking bench for uc_fsm against an opcode-class reference model.
module tb_uc_fsm;

  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic reset;

  uc_fsm_if #(.CNT_W(CNT_W)) bus ();

  uc_fsm #(
    .CNT_W    (CNT_W),
    .ALUOP_LI (3'b000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  // Reference state.
  bit m_halted;
  bit m_illegal;
  int m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected {s_inc, s_inm, we, wez, ALUOp[2:0]} from the instruction classes.
  function automatic logic [6:0] expect_ctrl(input int op, input bit z, input bit rst,
                                             input bit hlt);
    if (rst) return 7'b1000_000;
    if (hlt) return 7'b0000_000;
    if (op < 32) return {4'b1011, 3'(op / 4)};
    if (op < 36) return 7'b1110_000;
    case (op)
      36:      return 7'b0000_000;
      37:      return {~z, 6'b000_000};
      38:      return {z, 6'b000_000};
      39:      return 7'b0000_000;
      default: return 7'b1000_000;
    endcase
  endfunction

  task automatic cycle(input int op, input bit z, input bit rst);
    logic [6:0] e;
    reset      = rst;
    bus.Opcode = 6'(op);
    bus.zero   = z;
    #3;
    e = expect_ctrl(op, z, rst, m_halted);
    check("s_inc", 32'(bus.s_inc), 32'(e[6]));
    check("s_inm", 32'(bus.s_inm), 32'(e[5]));
    check("we", 32'(bus.we), 32'(e[4]));
    check("wez", 32'(bus.wez), 32'(e[3]));
    check("ALUOp", 32'(bus.ALUOp), 32'(e[2:0]));
    check("halted", 32'(bus.halted), 32'(m_halted));
    check("illegal", 32'(bus.illegal), 32'(m_illegal));
    check("instr_cnt", 32'(bus.instr_cnt), 32'(m_cnt));
    @(posedge clk);
    if (rst) begin
      m_halted  = 1'b0;
      m_illegal = 1'b0;
      m_cnt     = 0;
    end else if (!m_halted) begin
      m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
      if (op >= 40) m_illegal = 1'b1;
      if (op == 39) m_halted = 1'b1;
    end
    #1;
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    m_halted   = 1'b0;
    m_illegal  = 1'b0;
    m_cnt      = 0;
    reset      = 1'b1;
    bus.Opcode = 6'b001000;
    bus.zero   = 1'b0;
    @(posedge clk);
    #1;
    cycle(6'b001000, 1'b0, 1'b1);
    cycle(6'b001000, 1'b0, 1'b1);
    cycle(6'b001000, 1'b0, 1'b0);
    cycle(6'b001000, 1'b0, 1'b0);
    check("cnt_after_two", 32'(bus.instr_cnt), 32'd2);
    // LI, J, conditional branches both ways.
    cycle(6'b100011, 1'b0, 1'b0);
    cycle(6'b100100, 1'b0, 1'b0);
    cycle(6'b100101, 1'b1, 1'b0);
    cycle(6'b100101, 1'b0, 1'b0);
    cycle(6'b100110, 1'b1, 1'b0);
    cycle(6'b100110, 1'b0, 1'b0);
    // HALT, then random opcodes while parked, then reset.
    cycle(6'b100111, 1'b0, 1'b0);
    check("halted_after_halt", 32'(bus.halted), 32'd1);
    for (int i = 0; i < 5; i++) cycle(int'($urandom_range(0, 63)), 1'($urandom), 1'b0);
    cycle(0, 1'b0, 1'b1);
    check("halted_cleared", 32'(bus.halted), 32'd0);
    // Illegal opcode is sticky until reset.
    cycle(6'b110000, 1'b0, 1'b0);
    cycle(6'b000100, 1'b0, 1'b0);
    cycle(6'b011100, 1'b1, 1'b0);
    check("illegal_sticky", 32'(bus.illegal), 32'd1);
    cycle(0, 1'b0, 1'b1);
    // Saturation, then reset asserted mid-run.
    for (int i = 0; i < 20; i++) cycle(int'($urandom_range(0, 31)), 1'b0, 1'b0);
    check("cnt_saturated", 32'(bus.instr_cnt), 32'(CNT_MAX));
    cycle(6'b010000, 1'b1, 1'b1);
    cycle(6'b100000, 1'b1, 1'b1);
    // Random phase: HALT is rare so most time is spent in RUN.
    for (int i = 0; i < 600; i++) begin
      int op;
      bit rst;
      op = int'($urandom_range(0, 63));
      if (op == 39 && $urandom_range(0, 2) != 0) op = int'($urandom_range(0, 38));
      rst = ($urandom_range(0, 29) == 0) || (m_halted && $urandom_range(0, 5) == 0);
      cycle(op, 1'($urandom), rst);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
